// File: rtl/root_display_scheduler_if.sv
// Root-set handshake and 7-segment display bus for root_display_scheduler.
// slave = scheduler side, master = producer/observer side.
interface root_display_scheduler_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x1;
  logic [3:0] in_x2;
  logic [1:0] in_num_roots;
  logic [3:0] x1_out;
  logic [3:0] x2_out;
  logic       display_select;
  logic       blank;
  logic       swap_tick;

  modport slave (
    input  in_valid, in_x1, in_x2, in_num_roots,
    output in_ready, x1_out, x2_out, display_select, blank, swap_tick
  );

  modport master (
    output in_valid, in_x1, in_x2, in_num_roots,
    input  in_ready, x1_out, x2_out, display_select, blank, swap_tick
  );
endinterface

// File: rtl/root_display_scheduler.sv
// Latches a root set and alternates the 7-seg decoder between x1 and x2 every DWELL_CYCLES.
// Define ROOT_DISP_MANUAL_EN to replace the dwell timer with a btn_next rising-edge toggle.
module root_display_scheduler #(
  parameter logic [31:0] DWELL_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst,
`ifdef ROOT_DISP_MANUAL_EN
  input  logic btn_next,
`endif
  root_display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW_X1, SHOW_X2} state_t;

  state_t      state_q, state_d;
  logic        alt_en_q, alt_en_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  x1_q, x1_d;
  logic [3:0]  x2_q, x2_d;
  logic        sel_q, sel_d;
  logic        blank_q, blank_d;
  logic        tick_q, tick_d;
  logic [31:0] cnt_q, cnt_d;
  logic        xfer;
  logic        toggle;

  assign xfer = bus.in_valid && in_ready_q;

`ifdef ROOT_DISP_MANUAL_EN
  logic btn_prev_q;

  always_ff @(posedge clk) begin
    if (rst) btn_prev_q <= 1'b0;
    else     btn_prev_q <= btn_next;
  end

  assign toggle = alt_en_q && (state_q != IDLE) && btn_next && !btn_prev_q;
`else
  localparam logic [31:0] TERM = DWELL_CYCLES - 32'd1;

  assign toggle = alt_en_q && (state_q != IDLE) && (cnt_q == TERM);
`endif

  always_comb begin
    state_d    = state_q;
    alt_en_d   = alt_en_q;
    in_ready_d = 1'b1;
    x1_d       = x1_q;
    x2_d       = x2_q;
    sel_d      = sel_q;
    blank_d    = blank_q;
    tick_d     = 1'b0;
    cnt_d      = cnt_q;

    if (alt_en_q && (state_q != IDLE)) cnt_d = cnt_q + 32'd1;

    // A new root set always wins over a pending toggle.
    if (xfer) begin
      cnt_d = 32'd0;
      sel_d = 1'b0;
      case (bus.in_num_roots)
        2'd1: begin
          state_d  = SHOW_X1;
          alt_en_d = 1'b0;
          x1_d     = bus.in_x1;
          x2_d     = bus.in_x1;
          blank_d  = 1'b0;
        end
        2'd2: begin
          state_d  = SHOW_X1;
          alt_en_d = 1'b1;
          x1_d     = bus.in_x1;
          x2_d     = bus.in_x2;
          blank_d  = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          alt_en_d = 1'b0;
          x1_d     = 4'd0;
          x2_d     = 4'd0;
          blank_d  = 1'b1;
        end
      endcase
    end else if (toggle) begin
      state_d = (state_q == SHOW_X1) ? SHOW_X2 : SHOW_X1;
      sel_d   = ~sel_q;
      tick_d  = 1'b1;
      cnt_d   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alt_en_q   <= 1'b0;
      in_ready_q <= 1'b0;
      x1_q       <= 4'd0;
      x2_q       <= 4'd0;
      sel_q      <= 1'b0;
      blank_q    <= 1'b1;
      tick_q     <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      alt_en_q   <= alt_en_d;
      in_ready_q <= in_ready_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      sel_q      <= sel_d;
      blank_q    <= blank_d;
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.x1_out         = x1_q;
  assign bus.x2_out         = x2_q;
  assign bus.display_select = sel_q;
  assign bus.blank          = blank_q;
  assign bus.swap_tick      = tick_q;

endmodule

// File: tb/tb_root_display_scheduler.sv
// Directed plus randomized bench for root_display_scheduler against a cycle-count reference model.
// Define ROOT_DISP_MANUAL_EN to exercise the button-driven variant.
module tb_root_display_scheduler;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef ROOT_DISP_MANUAL_EN
  logic btn_next = 1'b0;
`endif

  root_display_scheduler_if bus_if ();

  root_display_scheduler #(.DWELL_CYCLES(32'(DWELL))) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ROOT_DISP_MANUAL_EN
    .btn_next (btn_next),
`endif
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = blanked, 1 = single root, 2 = two roots.
  int         cyc      = 0;
  int         m_load   = 0;
  int         m_mode   = 0;
  bit         m_ready  = 1'b0;
  logic [3:0] m_x1     = 4'd0;
  logic [3:0] m_x2     = 4'd0;
  bit         m_sel    = 1'b0;
  bit         m_tick   = 1'b0;
  bit         m_btn_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Predict the effect of the next rising edge, advance one clock, compare all outputs.
  task automatic step();
    bit xfer;
    int d;
    bit btn;
    btn = 1'b0;
`ifdef ROOT_DISP_MANUAL_EN
    btn = btn_next;
`endif
    cyc++;
    if (rst) begin
      m_mode = 0; m_ready = 1'b0; m_x1 = 4'd0; m_x2 = 4'd0;
      m_sel = 1'b0; m_tick = 1'b0; m_btn_prev = 1'b0;
    end else begin
      xfer    = bus_if.in_valid && m_ready;
      m_ready = 1'b1;
      m_tick  = 1'b0;
      if (xfer) begin
        m_load = cyc;
        m_sel  = 1'b0;
        case (bus_if.in_num_roots)
          2'd1:    begin m_mode = 1; m_x1 = bus_if.in_x1; m_x2 = bus_if.in_x1; end
          2'd2:    begin m_mode = 2; m_x1 = bus_if.in_x1; m_x2 = bus_if.in_x2; end
          default: begin m_mode = 0; m_x1 = 4'd0; m_x2 = 4'd0; end
        endcase
      end else if (m_mode == 2) begin
`ifdef ROOT_DISP_MANUAL_EN
        d = 0;
        if (btn && !m_btn_prev) begin
          m_sel  = !m_sel;
          m_tick = 1'b1;
        end
`else
        d      = cyc - m_load;
        m_sel  = ((d / DWELL) % 2) == 1;
        m_tick = (d % DWELL) == 0;
`endif
      end
      m_btn_prev = btn;
    end
    @(posedge clk);
    #1;
    check_val("in_ready",       32'(bus_if.in_ready),       32'(m_ready));
    check_val("x1_out",         32'(bus_if.x1_out),         32'(m_x1));
    check_val("x2_out",         32'(bus_if.x2_out),         32'(m_x2));
    check_val("display_select", 32'(bus_if.display_select), 32'(m_sel));
    check_val("blank",          32'(bus_if.blank),          32'(m_mode == 0));
    check_val("swap_tick",      32'(bus_if.swap_tick),      32'(m_tick));
  endtask

  task automatic load(input logic [1:0] n, input logic [3:0] a, input logic [3:0] b);
    bus_if.in_valid     = 1'b1;
    bus_if.in_num_roots = n;
    bus_if.in_x1        = a;
    bus_if.in_x2        = b;
    step();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus_if.in_valid     = 1'b0;
    bus_if.in_num_roots = 2'd0;
    bus_if.in_x1        = 4'd0;
    bus_if.in_x2        = 4'd0;

    // Reset state, then release.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    check_val("dir_ready_after_reset", 32'(bus_if.in_ready), 32'd1);

    // Two roots: -3 and 5, alternation every DWELL cycles.
    load(2'd2, 4'b1101, 4'd5);
    check_val("dir_x1_neg3", 32'(bus_if.x1_out), 32'hD);
    idle(3 * DWELL + 2);

    // Single root: no alternation.
    load(2'd1, 4'd7, 4'd2);
    idle(20);

    // Zero roots, then invalid count.
    load(2'd0, 4'd6, 4'd6);
    idle(2);
    load(2'd3, 4'd5, 4'd9);
    idle(2);

    // Transfer lands on the terminal-count edge while showing x1.
    load(2'd2, 4'd1, 4'd2);
    idle(DWELL - 1);
    load(2'd2, 4'd3, 4'd4);
    check_val("dir_tc_no_tick", 32'(bus_if.swap_tick), 32'd0);
    idle(2 * DWELL + 1);

    // Transfer while showing x2.
    load(2'd2, 4'd8, 4'd9);
    idle(DWELL + 1);
    load(2'd2, 4'd10, 4'd11);
    idle(2);

    // Reset mid-alternation with in_valid held.
    load(2'd2, 4'd12, 4'd13);
    idle(DWELL + 2);
    rst = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_num_roots = 2'd2;
    idle(2);
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    idle(DWELL + 2);

`ifdef ROOT_DISP_MANUAL_EN
    // Button held for 10 cycles gives exactly one toggle, no timer toggles afterwards.
    load(2'd2, 4'd1, 4'd6);
    btn_next = 1'b1;
    idle(10);
    btn_next = 1'b0;
    idle(3 * DWELL);
    check_val("dir_manual_one_toggle", 32'(bus_if.display_select), 32'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rst                 = ($urandom_range(0, 99) == 0);
      bus_if.in_valid     = ($urandom_range(0, 9) == 0);
      bus_if.in_num_roots = 2'($urandom_range(0, 3));
      bus_if.in_x1        = 4'($urandom);
      bus_if.in_x2        = 4'($urandom);
`ifdef ROOT_DISP_MANUAL_EN
      if ($urandom_range(0, 3) == 0) btn_next = ~btn_next;
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/root_display_scheduler.md
ROOT_DISPLAY_SCHEDULER -- requirements
Module: root_display_scheduler

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000000, giving the cycles each root is shown in alternation; legal range 2..2^32-1.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  new root set offered.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a root set.
REQ-006 The block SHALL have port in_x1  input  4  first root, signed two's complement.
REQ-007 The block SHALL have port in_x2  input  4  second root, signed two's complement.
REQ-008 The block SHALL have port in_num_roots  input  2  root count: 0, 1 or 2; value 3 means invalid.
REQ-009 The block SHALL have port x1_out  output  4  latched first root to the 7-seg decoder, signed.
REQ-010 The block SHALL have port x2_out  output  4  latched second root to the 7-seg decoder, signed.
REQ-011 The block SHALL have port display_select  output  1  decoder select: 0 = x1, 1 = x2.
REQ-012 The block SHALL have port blank  output  1  1 = decoder outputs are to be forced off.
REQ-013 The block SHALL have port swap_tick  output  1  one-cycle pulse on each display_select change.

Function
REQ-014 The block SHALL implement states IDLE, SHOW_X1 and SHOW_X2; all outputs are registered.
REQ-015 The block SHALL hold in_ready high in every state after reset, and a transfer SHALL occur on any clk edge with in_valid=1 and in_ready=1.
REQ-016 On a transfer, the block SHALL update x1_out, x2_out, state and blank at that same edge (latency 1 clock from the sampled request).
REQ-017 On a transfer with in_num_roots=0 or 3, the block SHALL enter IDLE with blank=1, display_select=0, x1_out=0 and x2_out=0.
REQ-018 On a transfer with in_num_roots=1, the block SHALL enter SHOW_X1 with x1_out=in_x1, x2_out=in_x1 and blank=0; it SHALL then hold with no alternation.
REQ-019 On a transfer with in_num_roots=2, the block SHALL enter SHOW_X1 with x1_out=in_x1, x2_out=in_x2 and blank=0; alternation is then enabled.
REQ-020 The dwell counter SHALL be 32 bits, clear on every transfer and on every toggle, and increment each cycle in SHOW_X1 or SHOW_X2 while alternation is enabled.
REQ-021 When the dwell counter equals DWELL_CYCLES-1, the block SHALL toggle SHOW_X1<->SHOW_X2, flip display_select and pulse swap_tick for one cycle at the same edge.
REQ-022 If a transfer and a dwell terminal count occur at the same edge, the transfer SHALL win: no toggle, swap_tick=0, state SHOW_X1.
REQ-023 A transfer arriving while in SHOW_X2 SHALL return the block to SHOW_X1 with display_select=0 at that edge.
REQ-024 The block SHALL keep x1_out and x2_out stable between transfers.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL set state=IDLE, in_ready=0, blank=1, display_select=0, x1_out=0, x2_out=0, swap_tick=0 and dwell counter=0; reset SHALL override a simultaneous transfer.
REQ-026 On the first edge after rst deasserts, the block SHALL set in_ready=1.

Configuration
REQ-027 With ROOT_DISP_MANUAL_EN defined, the block SHALL add port btn_next  input  1  (debounced, synchronous to clk) and SHALL disable automatic dwell toggling.
REQ-028 With ROOT_DISP_MANUAL_EN defined, each 0->1 edge of btn_next (registered previous-value detect) SHALL, with 2 roots loaded, toggle the state and pulse swap_tick one cycle after the edge is sampled; a transfer in the same cycle SHALL win, and the edge SHALL be ignored in IDLE and with 1 root.
REQ-029 Without ROOT_DISP_MANUAL_EN, btn_next SHALL be absent and behaviour SHALL be as in REQ-020 to REQ-022.

Verification
REQ-030 DWELL_CYCLES=4; reset, then load num_roots=2, x1=-3, x2=5 -> x1_out=4'b1101, x2_out=5, blank=0; display_select toggles 0->1->0 every 4 cycles with a swap_tick at each toggle.
REQ-031 Load num_roots=1, x1=7 -> x1_out=x2_out=7, display_select stays 0 for 20 cycles, no swap_tick.
REQ-032 Load num_roots=0, then separately num_roots=3 -> each time blank=1, outputs 0, state IDLE.
REQ-033 Present a transfer on the terminal-count cycle while in SHOW_X1 -> no swap_tick, display_select=0, counter restarts from 0.
REQ-034 Assert rst mid-alternation while in_valid=1 -> all outputs at reset values and in_ready=0 during reset; in_ready=1 on the edge after release.
REQ-035 With ROOT_DISP_MANUAL_EN, load 2 roots and hold btn_next high 10 cycles -> exactly one toggle; no auto toggle after 3*DWELL_CYCLES.
